// File: rtl/frc_timer_intc_pkg.sv
// Shared constants for the machine timer / external interrupt front end:
// register word addresses, CTRL bit positions and privilege encodings.
package frc_timer_intc_pkg;

    localparam logic [2:0] FRC_ADR_MTIME_LO    = 3'd0;
    localparam logic [2:0] FRC_ADR_MTIME_HI    = 3'd1;
    localparam logic [2:0] FRC_ADR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] FRC_ADR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] FRC_ADR_CTRL        = 3'd4;
    localparam logic [2:0] FRC_ADR_EIP         = 3'd5;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_EDGE = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        U_MODE = 2'b00,
        S_MODE = 2'b01,
        M_MODE = 2'b11
    } priv_t;

endpackage

// File: rtl/frc_timer_intc_int_sync_edge.sv
// 2-FF synchroniser for an async interrupt line plus a level/edge pending latch with W1C.
// Level mode passes the synchronised line; edge mode latches a rising edge (set beats clear).
module frc_timer_intc_int_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    input  logic edge_mode,
    input  logic clr,
    output logic pending
);

    logic meta;
    logic ext_s;
    logic ext_d;
    logic edge_mode_d;
    logic latched;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta        <= 1'b0;
            ext_s       <= 1'b0;
            ext_d       <= 1'b0;
            edge_mode_d <= 1'b0;
            latched     <= 1'b0;
        end else begin
            meta        <= async_in;
            ext_s       <= meta;
            ext_d       <= ext_s;
            edge_mode_d <= edge_mode;
            // A mode change discards whatever was latched under the old mode.
            if (edge_mode != edge_mode_d) begin
                latched <= 1'b0;
            end else if (edge_mode && ext_s && !ext_d) begin
                latched <= 1'b1;
            end else if (edge_mode && clr) begin
                latched <= 1'b0;
            end
        end
    end

    assign pending = edge_mode ? latched : ext_s;

endmodule

// File: rtl/frc_timer_intc.sv
// Machine timer (prescaled 64-bit mtime vs mtimecmp) and external interrupt front end
// with a word-addressed register port; reads return one cycle after the strobe.
module frc_timer_intc
    import frc_timer_intc_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int PSC_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [2:0]  reg_adr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_rvalid,
    input  logic        ext_int_in,
    input  logic        csr_mtie,
    input  logic        csr_meie,
    output logic        frc_cntr_val_leq,
    output logic        g_interrupt,
    output logic        g_interrupt_1shot,
    output logic [1:0]  g_interrupt_priv
);

    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc;
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic [31:0]      cmp_shadow;
    logic [31:0]      mtime_hi_snap;
    logic             run;
    logic             edge_mode;
    logic             pending;
    logic             g_interrupt_d;
    logic             wr_mtime_lo;
    logic             wr_mtime_hi;
    logic             tick;
    logic             eip_clr;
    logic [31:0]      rd_mux;

    assign wr_mtime_lo = reg_wr && (reg_adr == FRC_ADR_MTIME_LO);
    assign wr_mtime_hi = reg_wr && (reg_adr == FRC_ADR_MTIME_HI);
    assign tick        = run && (psc == PSC_LAST);
    assign eip_clr     = reg_wr && (reg_adr == FRC_ADR_EIP) && reg_wdata[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc        <= '0;
            mtime      <= '0;
            mtimecmp   <= MTIMECMP_RST;
            cmp_shadow <= '1;
            run        <= 1'b0;
            edge_mode  <= 1'b0;
        end else begin
            if (wr_mtime_lo || wr_mtime_hi) begin
                psc <= '0;
            end else if (run) begin
                psc <= tick ? '0 : psc + 1'b1;
            end
            // Software writes win over a coinciding increment; no carry into HI.
            if (wr_mtime_lo) begin
                mtime[31:0] <= reg_wdata;
            end else if (wr_mtime_hi) begin
                mtime[63:32] <= reg_wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (reg_wr) begin
                case (reg_adr)
                    FRC_ADR_MTIMECMP_LO: cmp_shadow <= reg_wdata;
                    FRC_ADR_MTIMECMP_HI: mtimecmp   <= {reg_wdata, cmp_shadow};
                    FRC_ADR_CTRL: begin
                        run       <= reg_wdata[CTRL_RUN];
                        edge_mode <= reg_wdata[CTRL_EDGE];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_adr)
            FRC_ADR_MTIME_LO:    rd_mux = mtime[31:0];
            FRC_ADR_MTIME_HI:    rd_mux = mtime_hi_snap;
            FRC_ADR_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
            FRC_ADR_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
            FRC_ADR_CTRL:        rd_mux = {30'd0, edge_mode, run};
            FRC_ADR_EIP:         rd_mux = {31'd0, pending};
            default:             rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata     <= '0;
            reg_rvalid    <= 1'b0;
            mtime_hi_snap <= '0;
        end else begin
            reg_rvalid <= reg_rd;
            if (reg_rd) begin
                reg_rdata <= rd_mux;
                // LO read freezes HI so a following HI read is coherent with it.
                if (reg_adr == FRC_ADR_MTIME_LO) begin
                    mtime_hi_snap <= mtime[63:32];
                end
            end
        end
    end

    frc_timer_intc_int_sync_edge u_ext_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_in  (ext_int_in),
        .edge_mode (edge_mode),
        .clr       (eip_clr),
        .pending   (pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frc_cntr_val_leq <= 1'b0;
            g_interrupt      <= 1'b0;
            g_interrupt_d    <= 1'b0;
        end else begin
            frc_cntr_val_leq <= run && csr_mtie && (mtimecmp <= mtime);
            g_interrupt      <= pending && csr_meie;
            g_interrupt_d    <= g_interrupt;
        end
    end

    assign g_interrupt_1shot = g_interrupt && !g_interrupt_d;
    assign g_interrupt_priv  = M_MODE;

endmodule

// File: tb/tb_frc_timer_intc.sv
// Bench for frc_timer_intc: elapsed-cycle reference model feeding a read scoreboard,
// per-cycle timer request check, and directed external interrupt scenarios.
module tb_frc_timer_intc;

    localparam int PSC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [2:0]  reg_adr = 3'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        ext_int_in = 1'b0;
    logic        csr_mtie = 1'b0;
    logic        csr_meie = 1'b0;
    logic        frc_cntr_val_leq;
    logic        g_interrupt;
    logic        g_interrupt_1shot;
    logic [1:0]  g_interrupt_priv;

    always #5 clk = ~clk;

    frc_timer_intc #(.PRESCALE(PSC), .PSC_W(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .reg_wr            (reg_wr),
        .reg_rd            (reg_rd),
        .reg_adr           (reg_adr),
        .reg_wdata         (reg_wdata),
        .reg_rdata         (reg_rdata),
        .reg_rvalid        (reg_rvalid),
        .ext_int_in        (ext_int_in),
        .csr_mtie          (csr_mtie),
        .csr_meie          (csr_meie),
        .frc_cntr_val_leq  (frc_cntr_val_leq),
        .g_interrupt       (g_interrupt),
        .g_interrupt_1shot (g_interrupt_1shot),
        .g_interrupt_priv  (g_interrupt_priv)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mtime = value last written + whole prescale periods spent running since.
    logic [63:0]     m_base;
    longint unsigned m_runcyc;
    logic [63:0]     m_cmp;
    logic [31:0]     m_shadow;
    logic [31:0]     m_snap;
    logic            m_run;
    logic            m_edge;
    logic            exp_leq;
    logic [31:0]     exp_eip = 32'd0;
    logic [31:0]     exp_q[$];

    function automatic logic [63:0] cur_mtime();
        return m_base + 64'(m_runcyc / longint'(PSC));
    endfunction

    task automatic model_reset();
        m_base   = 64'd0;
        m_runcyc = 0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_shadow = 32'hFFFF_FFFF;
        m_snap   = 32'd0;
        m_run    = 1'b0;
        m_edge   = 1'b0;
        exp_leq  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [63:0] cur;
        logic [31:0] rv;
        cur     = cur_mtime();
        exp_leq = m_run & csr_mtie & (m_cmp <= cur);
        if (reg_rd) begin
            case (reg_adr)
                3'd0:    rv = cur[31:0];
                3'd1:    rv = m_snap;
                3'd2:    rv = m_cmp[31:0];
                3'd3:    rv = m_cmp[63:32];
                3'd4:    rv = {30'd0, m_edge, m_run};
                3'd5:    rv = exp_eip;
                default: rv = 32'd0;
            endcase
            exp_q.push_back(rv);
            if (reg_adr == 3'd0) m_snap = cur[63:32];
        end
        if (m_run) m_runcyc++;
        if (reg_wr) begin
            case (reg_adr)
                3'd0: begin m_base = {cur[63:32], reg_wdata}; m_runcyc = 0; end
                3'd1: begin m_base = {reg_wdata, cur[31:0]};  m_runcyc = 0; end
                3'd2: m_shadow = reg_wdata;
                3'd3: m_cmp = {reg_wdata, m_shadow};
                3'd4: begin m_run = reg_wdata[0]; m_edge = reg_wdata[1]; end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Monitor: pop and compare on every returned read; timer request checked every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata_unexpected: got %h, expected no read response", reg_rdata);
                end else begin
                    chk("rdata", reg_rdata, exp_q.pop_front());
                end
            end
            chk("frc_cntr_val_leq", frc_cntr_val_leq, exp_leq);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_adr = a; reg_wdata = d;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        reg_rd = 1'b1; reg_adr = a;
        @(negedge clk);
        reg_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rise;
        int shots;
        logic [2:0]  a;
        logic [31:0] d;

        // Reset state and full register readback
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("reset_leq", frc_cntr_val_leq, 1'b0);
        chk("reset_g_interrupt", g_interrupt, 1'b0);
        chk("reset_1shot", g_interrupt_1shot, 1'b0);
        chk("reset_priv", g_interrupt_priv, 2'b11);
        chk("reset_rvalid", reg_rvalid, 1'b0);
        for (int i = 0; i < 8; i++) rd(3'(i));
        idle(2);

        // Timer interrupt with PRESCALE=4
        csr_mtie = 1'b1;
        wr(3'd2, 32'd10);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd1);
        n = 0;
        while (!frc_cntr_val_leq && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("t2_leq_rise", frc_cntr_val_leq, 1'b1);
        chk("t2_rise_after_40", (n >= 38 && n <= 42), 1'b1);
        wr(3'd2, 32'd100);
        wr(3'd3, 32'd0);
        idle(2);
        chk("t2_leq_fall", frc_cntr_val_leq, 1'b0);

        // Atomic compare commit
        wr(3'd4, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd1);
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd2);
        wr(3'd4, 32'd1);
        wr(3'd2, 32'd0);
        idle(5);
        chk("t3_no_early_assert", frc_cntr_val_leq, 1'b0);
        wr(3'd3, 32'd0);
        idle(1);
        chk("t3_assert_after_hi", frc_cntr_val_leq, 1'b1);

        // Coherent LO/HI read across a carry
        wr(3'd4, 32'd0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd1, 32'd1);
        wr(3'd4, 32'd1);
        rd(3'd0);
        idle(20);
        rd(3'd1);
        idle(2);
        wr(3'd4, 32'd0);

        // Randomised register traffic against the model
        repeat (400) begin
            a = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 60));
            case ($urandom_range(0, 5))
                0, 1: wr(a, d);
                2, 3: rd(a);
                4: begin
                    reg_rd = 1'b1; reg_wr = 1'b1; reg_adr = a; reg_wdata = d;
                    @(negedge clk);
                    reg_rd = 1'b0; reg_wr = 1'b0;
                end
                default: begin
                    csr_mtie = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
            endcase
        end
        idle(3);

        // External edge mode
        do_reset();
        wr(3'd4, 32'd3);
        csr_meie = 1'b1;
        idle(2);
        ext_int_in = 1'b1;
        @(negedge clk);
        ext_int_in = 1'b0;
        rise = 0;
        shots = 0;
        for (int i = 1; i <= 8; i++) begin
            if (g_interrupt && rise == 0) rise = i;
            shots += int'(g_interrupt_1shot);
            @(negedge clk);
        end
        chk("t5_rise_within_4", (rise >= 3 && rise <= 4), 1'b1);
        chk("t5_oneshot_count", 32'(shots), 32'd1);
        chk("t5_level_held", g_interrupt, 1'b1);
        ext_int_in = 1'b1;
        @(negedge clk);
        ext_int_in = 1'b0;
        @(negedge clk);
        wr(3'd5, 32'd1);
        exp_eip = 32'd1;
        rd(3'd5);
        idle(2);
        chk("t5_set_beats_clear", g_interrupt, 1'b1);
        wr(3'd5, 32'd1);
        exp_eip = 32'd0;
        idle(2);
        chk("t5_w1c_clears", g_interrupt, 1'b0);
        rd(3'd5);
        idle(2);

        // Level mode with enable gating, then async reset mid-hold
        wr(3'd4, 32'd0);
        csr_meie = 1'b0;
        ext_int_in = 1'b1;
        idle(6);
        chk("t6_gated_off", g_interrupt, 1'b0);
        chk("t6_gated_1shot", g_interrupt_1shot, 1'b0);
        exp_eip = 32'd1;
        rd(3'd5);
        wr(3'd5, 32'd1);
        rd(3'd5);
        idle(2);
        csr_mtie = 1'b1;
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd1);
        idle(1);
        chk("t6_timer_high", frc_cntr_val_leq, 1'b1);
        csr_meie = 1'b1;
        @(negedge clk);
        chk("t6_g_interrupt_rise", g_interrupt, 1'b1);
        chk("t6_1shot_fire", g_interrupt_1shot, 1'b1);
        @(negedge clk);
        chk("t6_1shot_once", g_interrupt_1shot, 1'b0);
        chk("t6_level_hold", g_interrupt, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_leq", frc_cntr_val_leq, 1'b0);
        chk("t6_rst_g_interrupt", g_interrupt, 1'b0);
        chk("t6_rst_1shot", g_interrupt_1shot, 1'b0);
        chk("t6_rst_rvalid", reg_rvalid, 1'b0);
        chk("t6_rst_rdata", reg_rdata, 32'd0);
        chk("t6_rst_priv", g_interrupt_priv, 2'b11);
        @(negedge clk);
        ext_int_in = 1'b0;
        exp_eip = 32'd0;
        rst_n = 1'b1;
        idle(3);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
